// File: rtl/iobuf_bank.sv
// iobuf_bank: per-channel IO buffer mode control with break-before-make dead time and synchronized input readback
// Ports: clock/reset (async active-high); mode_req[2*CH] per-channel 00 HiZ, 01 push-pull, 10 open-drain, 11 HiZ;
// din drive value; dout/dout_edge synchronized pin value and change pulse; busy dead-time flag;
// bufdir/bufod/bufdat_tristate_oe/bufdat_tristate_dout external buffer controls; bufdat_tristate_din raw pin input.
module iobuf_bank #(
  parameter int CHANNELS    = 8,
  parameter int TURN_CYCLES = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [2*CHANNELS-1:0] mode_req,
  input  logic [CHANNELS-1:0]   din,
  output logic [CHANNELS-1:0]   dout,
  output logic [CHANNELS-1:0]   dout_edge,
  output logic [CHANNELS-1:0]   busy,
  output logic [CHANNELS-1:0]   bufdir,
  output logic [CHANNELS-1:0]   bufod,
  output logic [CHANNELS-1:0]   bufdat_tristate_oe,
  output logic [CHANNELS-1:0]   bufdat_tristate_dout,
  input  logic [CHANNELS-1:0]   bufdat_tristate_din
);
  localparam int CW = $clog2(TURN_CYCLES + 1);
  localparam logic [1:0] HIZ = 2'b00, PP = 2'b01, OD = 2'b10;
  typedef enum logic {STABLE, TURN} state_t;
  for (genvar g = 0; g < CHANNELS; g++) begin : ch
    state_t state, state_n;
    logic [1:0] cur, cur_n, tgt, tgt_n, req, eff;
    logic [CW-1:0] cnt, cnt_n;
    logic [SYNC_STAGES-1:0] sync;
    logic dir_q, oe_q, od_q, tdo_q, busy_q, edge_q;
    assign req = mode_req[2*g +: 2] == 2'b11 ? HIZ : mode_req[2*g +: 2];
    always_comb begin
      state_n = state;
      cur_n   = cur;
      tgt_n   = tgt;
      cnt_n   = cnt;
      if (state == STABLE) begin
        if (req != cur) begin
          if (req == HIZ) begin
            cur_n = HIZ;
          end else begin
            state_n = TURN;
            tgt_n   = req;
            cnt_n   = CW'(TURN_CYCLES);
          end
        end
      end else if (req == HIZ) begin
        state_n = STABLE;
        cur_n   = HIZ;
      end else if (req != tgt) begin
        // a new driving target restarts the whole dead-time window
        tgt_n = req;
        cnt_n = CW'(TURN_CYCLES);
      end else begin
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = STABLE;
          cur_n   = tgt;
        end
      end
    end
    // pins are computed from next state so they change on the same edge as the FSM
    assign eff = state_n == TURN ? HIZ : cur_n;
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state  <= STABLE;
        cur    <= HIZ;
        tgt    <= HIZ;
        cnt    <= '0;
        dir_q  <= 1'b0;
        oe_q   <= 1'b0;
        od_q   <= 1'b1;
        tdo_q  <= 1'b0;
        busy_q <= 1'b0;
        edge_q <= 1'b0;
        sync   <= '0;
      end else begin
        state  <= state_n;
        cur    <= cur_n;
        tgt    <= tgt_n;
        cnt    <= cnt_n;
        dir_q  <= eff == PP;
        oe_q   <= eff == PP;
        od_q   <= eff == OD ? din[g] : 1'b1;
        tdo_q  <= din[g];
        busy_q <= state_n == TURN;
        edge_q <= sync[SYNC_STAGES-2] != sync[SYNC_STAGES-1];
        sync   <= {sync[SYNC_STAGES-2:0], bufdat_tristate_din[g]};
      end
    end
    assign bufdir[g]               = dir_q;
    assign bufdat_tristate_oe[g]   = oe_q;
    assign bufod[g]                = od_q;
    assign bufdat_tristate_dout[g] = tdo_q;
    assign busy[g]                 = busy_q;
    assign dout_edge[g]            = edge_q;
    assign dout[g]                 = sync[SYNC_STAGES-1];
    // the level shifter must never drive while the open-drain buffer pulls low
    assert property (@(posedge clock) disable iff (reset) !(dir_q && !od_q));
  end
endmodule

// File: tb/tb_iobuf_bank.sv
// tb_iobuf_bank: scoreboard bench for iobuf_bank mode FSM, pin outputs, input sync and async reset
module tb_iobuf_bank;
  localparam int CH = 8;
  logic clock = 1'b0, reset = 1'b1;
  logic [2*CH-1:0] mode_req = '0;
  logic [CH-1:0] din = '0, tdin = '0;
  logic [CH-1:0] dout, dout_edge, busy, bufdir, bufod, oe, tdo;
  int total = 0, bad = 0;
  typedef struct {string tag; int ch; logic [4:0] v;} pexp_t;
  typedef struct {string tag; int ch; logic [1:0] v;} iexp_t;
  pexp_t pq[$];
  iexp_t iq[$];
  pexp_t pe;
  iexp_t ie;
  iobuf_bank #(.CHANNELS(CH), .TURN_CYCLES(2), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .mode_req(mode_req), .din(din),
    .dout(dout), .dout_edge(dout_edge), .busy(busy), .bufdir(bufdir), .bufod(bufod),
    .bufdat_tristate_oe(oe), .bufdat_tristate_dout(tdo), .bufdat_tristate_din(tdin)
  );
  always #5 clock = ~clock;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  // {busy, bufdir, oe, bufod, tristate_dout}
  function automatic logic [4:0] pins(int c);
    return {busy[c], bufdir[c], oe[c], bufod[c], tdo[c]};
  endfunction
  function automatic logic [4:0] turn(logic d);
    return {4'b1001, d};
  endfunction
  function automatic logic [4:0] ppm(logic d);
    return {4'b0111, d};
  endfunction
  function automatic logic [4:0] odm(logic d);
    return {3'b000, d, d};
  endfunction
  function automatic logic [4:0] hiz(logic d);
    return {4'b0001, d};
  endfunction
  task automatic set_mode(int c, logic [1:0] m);
    mode_req[2*c +: 2] = m;
  endtask
  task automatic test_reset;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1 total++;
      if (bufdir !== '0 || oe !== '0 || bufod !== '1 || busy !== '0 || dout !== '0 || dout_edge !== '0 || tdo !== '0) begin
        bad++;
        $display("FAIL reset_idle cyc%0d got dir=%b oe=%b od=%b busy=%b dout=%b edge=%b tdo=%b want safe", i, bufdir, oe, bufod, busy, dout, dout_edge, tdo);
      end
    end
  endtask
  task automatic test_pp_entry;
    din[0] = 1'b1;
    set_mode(0, 2'b01);
    pq.push_back('{"pp_turn0", 0, turn(1)});
    pq.push_back('{"pp_turn1", 0, turn(1)});
    pq.push_back('{"pp_drive", 0, ppm(1)});
    pq.push_back('{"pp_hold", 0, ppm(1)});
    while (pq.size() > 0) begin
      pe = pq.pop_front();
      @(posedge clock);
      #1 total++;
      if (pins(pe.ch) !== pe.v) begin
        bad++;
        $display("FAIL %s ch%0d got=%b want=%b", pe.tag, pe.ch, pins(pe.ch), pe.v);
      end
    end
  endtask
  task automatic test_pp_to_od;
    din[1] = 1'b0;
    set_mode(1, 2'b01);
    pq.push_back('{"ch1_turn0", 1, turn(0)});
    pq.push_back('{"ch1_turn1", 1, turn(0)});
    pq.push_back('{"ch1_pp", 1, ppm(0)});
    while (pq.size() > 0) begin
      pe = pq.pop_front();
      @(posedge clock);
      #1 total++;
      if (pins(pe.ch) !== pe.v) begin
        bad++;
        $display("FAIL %s ch%0d got=%b want=%b", pe.tag, pe.ch, pins(pe.ch), pe.v);
      end
    end
    set_mode(1, 2'b10);
    pq.push_back('{"od_dead0", 1, turn(0)});
    pq.push_back('{"od_dead1", 1, turn(0)});
    pq.push_back('{"od_low", 1, odm(0)});
    for (int i = 0; i < 3; i++) begin
      pe = pq.pop_front();
      @(posedge clock);
      #1 total++;
      if (pins(pe.ch) !== pe.v) begin
        bad++;
        $display("FAIL %s ch%0d got=%b want=%b", pe.tag, pe.ch, pins(pe.ch), pe.v);
      end
    end
    for (int i = 0; i < 4; i++) begin
      din[1] = ~din[1];
      pq.push_back('{"od_track", 1, odm(din[1])});
      pe = pq.pop_front();
      @(posedge clock);
      #1 total++;
      if (pins(pe.ch) !== pe.v) begin
        bad++;
        $display("FAIL %s ch%0d step%0d got=%b want=%b", pe.tag, pe.ch, i, pins(pe.ch), pe.v);
      end
    end
  endtask
  task automatic test_retarget_cancel;
    din[2] = 1'b0;
    set_mode(2, 2'b01);
    pq.push_back('{"rt_turn", 2, turn(0)});
    pe = pq.pop_front();
    @(posedge clock);
    #1 total++;
    if (pins(pe.ch) !== pe.v) begin
      bad++;
      $display("FAIL %s ch%0d got=%b want=%b", pe.tag, pe.ch, pins(pe.ch), pe.v);
    end
    set_mode(2, 2'b10);
    pq.push_back('{"rt_reload", 2, turn(0)});
    pq.push_back('{"rt_count", 2, turn(0)});
    pq.push_back('{"rt_od", 2, odm(0)});
    while (pq.size() > 0) begin
      pe = pq.pop_front();
      @(posedge clock);
      #1 total++;
      if (pins(pe.ch) !== pe.v) begin
        bad++;
        $display("FAIL %s ch%0d got=%b want=%b", pe.tag, pe.ch, pins(pe.ch), pe.v);
      end
    end
    set_mode(2, 2'b01);
    pq.push_back('{"cx_turn", 2, turn(0)});
    pe = pq.pop_front();
    @(posedge clock);
    #1 total++;
    if (pins(pe.ch) !== pe.v) begin
      bad++;
      $display("FAIL %s ch%0d got=%b want=%b", pe.tag, pe.ch, pins(pe.ch), pe.v);
    end
    set_mode(2, 2'b00);
    pq.push_back('{"cx_hiz", 2, hiz(0)});
    pq.push_back('{"cx_hold", 2, hiz(0)});
    while (pq.size() > 0) begin
      pe = pq.pop_front();
      @(posedge clock);
      #1 total++;
      if (pins(pe.ch) !== pe.v) begin
        bad++;
        $display("FAIL %s ch%0d got=%b want=%b", pe.tag, pe.ch, pins(pe.ch), pe.v);
      end
    end
    set_mode(2, 2'b11);
    pq.push_back('{"m11_hiz0", 2, hiz(0)});
    pq.push_back('{"m11_hiz1", 2, hiz(0)});
    while (pq.size() > 0) begin
      pe = pq.pop_front();
      @(posedge clock);
      #1 total++;
      if (pins(pe.ch) !== pe.v) begin
        bad++;
        $display("FAIL %s ch%0d got=%b want=%b", pe.tag, pe.ch, pins(pe.ch), pe.v);
      end
    end
    set_mode(2, 2'b00);
  endtask
  task automatic test_sync;
    tdin[3] = 1'b1;
    iq.push_back('{"rise_s1", 3, 2'b00});
    iq.push_back('{"rise_s2", 3, 2'b11});
    iq.push_back('{"rise_hold", 3, 2'b10});
    iq.push_back('{"rise_hold2", 3, 2'b10});
    while (iq.size() > 0) begin
      ie = iq.pop_front();
      @(posedge clock);
      #1 total++;
      if ({dout[ie.ch], dout_edge[ie.ch]} !== ie.v) begin
        bad++;
        $display("FAIL %s ch%0d got dout/edge=%b want=%b", ie.tag, ie.ch, {dout[ie.ch], dout_edge[ie.ch]}, ie.v);
      end
    end
    tdin[3] = 1'b0;
    iq.push_back('{"fall_s1", 3, 2'b10});
    iq.push_back('{"fall_s2", 3, 2'b01});
    iq.push_back('{"fall_hold", 3, 2'b00});
    while (iq.size() > 0) begin
      ie = iq.pop_front();
      @(posedge clock);
      #1 total++;
      if ({dout[ie.ch], dout_edge[ie.ch]} !== ie.v) begin
        bad++;
        $display("FAIL %s ch%0d got dout/edge=%b want=%b", ie.tag, ie.ch, {dout[ie.ch], dout_edge[ie.ch]}, ie.v);
      end
    end
  endtask
  task automatic test_async_reset;
    din[1] = 1'b1;
    set_mode(1, 2'b01);
    pq.push_back('{"ar_ch1_t0", 1, turn(1)});
    pq.push_back('{"ar_ch1_t1", 1, turn(1)});
    pq.push_back('{"ar_ch1_pp", 1, ppm(1)});
    while (pq.size() > 0) begin
      pe = pq.pop_front();
      @(posedge clock);
      #1 total++;
      if (pins(pe.ch) !== pe.v) begin
        bad++;
        $display("FAIL %s ch%0d got=%b want=%b", pe.tag, pe.ch, pins(pe.ch), pe.v);
      end
    end
    set_mode(0, 2'b10);
    @(posedge clock);
    #1 total++;
    if (pins(0) !== turn(1)) begin
      bad++;
      $display("FAIL ar_ch0_turn got=%b want=%b", pins(0), turn(1));
    end
    #2 reset = 1'b1;
    #1 total++;
    if (bufdir !== '0 || oe !== '0 || bufod !== '1 || busy !== '0 || tdo !== '0) begin
      bad++;
      $display("FAIL ar_async got dir=%b oe=%b od=%b busy=%b tdo=%b want safe", bufdir, oe, bufod, busy, tdo);
    end
    set_mode(0, 2'b00);
    @(posedge clock);
    #3 reset = 1'b0;
    pq.push_back('{"ar_rel_t0", 1, turn(1)});
    pq.push_back('{"ar_rel_t1", 1, turn(1)});
    pq.push_back('{"ar_rel_pp", 1, ppm(1)});
    while (pq.size() > 0) begin
      pe = pq.pop_front();
      @(posedge clock);
      #1 total++;
      if (pins(pe.ch) !== pe.v || pins(0) !== hiz(1)) begin
        bad++;
        $display("FAIL %s ch1=%b want=%b ch0=%b want=%b", pe.tag, pins(1), pe.v, pins(0), hiz(1));
      end
    end
  endtask
  initial begin
    test_reset;
    test_pp_entry;
    test_pp_to_od;
    test_retarget_cancel;
    test_sync;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
